// File: rtl/branch_predict_unit_pkg.sv
// Shared types and helpers for the branch predictor: counter constants,
// PC index/tag slicing and the mispredict cause encoding.
package branch_predict_unit_pkg;

  typedef enum logic [1:0] {
    MP_NONE  = 2'd0,
    MP_DIR   = 2'd1,
    MP_TGT   = 2'd2,
    MP_ALIAS = 2'd3
  } mp_cause_e;

  // Weakly-taken encoding: MSB set, all lower bits clear.
  function automatic int unsigned ctr_weak_t(input int unsigned w);
    return 32'd1 << (w - 32'd1);
  endfunction

  // Word-aligned index bits of a PC, returned zero-extended.
  function automatic logic [63:0] pc_index(input logic [63:0] pc, input int unsigned idx_w);
    return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  // Everything above the index bits.
  function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int unsigned idx_w);
    return pc >> (idx_w + 32'd2);
  endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Pipeline <-> predictor connection: IF lookup, EX resolution, redirect and stats.
interface branch_predict_unit_if #(
  parameter int ADDR_W = 32,
  parameter int STAT_W = 32
);
  logic [ADDR_W-1:0] fetch_pc;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic              ex_valid;
  logic              ex_is_branch;
  logic [ADDR_W-1:0] ex_pc;
  logic [ADDR_W-1:0] ex_pc_4;
  logic              ex_taken;
  logic [ADDR_W-1:0] ex_target;
  logic              ex_pred_taken;
  logic [ADDR_W-1:0] ex_pred_target;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic [STAT_W-1:0] branch_cnt;
  logic [STAT_W-1:0] mispredict_cnt;

  modport master (
    output fetch_pc, ex_valid, ex_is_branch, ex_pc, ex_pc_4, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target,
    input  pred_taken, pred_target, redirect, redirect_pc, branch_cnt, mispredict_cnt
  );

  modport slave (
    input  fetch_pc, ex_valid, ex_is_branch, ex_pc, ex_pc_4, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target,
    output pred_taken, pred_target, redirect, redirect_pc, branch_cnt, mispredict_cnt
  );
endinterface

// File: rtl/branch_predict_unit_sat_counter.sv
// Saturating up/down counter with parallel load; clamps at zero and all-ones.
module branch_predict_unit_sat_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value
);

  logic [W-1:0] value_r;

  // Load wins; simultaneous inc and dec cancel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_r <= {W{1'b0}};
    end else if (load) begin
      value_r <= load_val;
    end else if (inc && !dec && (value_r != {W{1'b1}})) begin
      value_r <= value_r + W'(1);
    end else if (dec && !inc && (value_r != {W{1'b0}})) begin
      value_r <= value_r - W'(1);
    end else begin
      value_r <= value_r;
    end
  end

  assign value = value_r;

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with saturating direction counters, EX-stage resolution,
// registered one-cycle redirect and saturating branch/mispredict statistics.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int ADDR_W  = 32,
  parameter int STAT_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_predict_unit_if.slave  bus
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - 2 - IDX_W;
  localparam logic [CTR_W-1:0] CTR_WEAK_T = CTR_W'(ctr_weak_t(CTR_W));

  logic [ENTRIES-1:0] valid_r;
  logic [TAG_W-1:0]   tag_r    [ENTRIES];
  logic [ADDR_W-1:0]  target_r [ENTRIES];
  logic [CTR_W-1:0]   ctr_s    [ENTRIES];

  logic              redirect_r;
  logic [ADDR_W-1:0] redirect_pc_r;

  logic [IDX_W-1:0]  f_idx_s;
  logic [TAG_W-1:0]  f_tag_s;
  logic              f_hit_s;
  logic              f_taken_s;
  logic [IDX_W-1:0]  e_idx_s;
  logic [TAG_W-1:0]  e_tag_s;
  logic              e_hit_s;
  logic              res_s;
  mp_cause_e         cause_s;
  logic              mp_s;
  logic [ADDR_W-1:0] fix_pc_s;
  logic              wr_alloc_s;
  logic              wr_tgt_s;
  logic              wr_inval_s;
  logic              ctr_inc_s;
  logic              ctr_dec_s;

  // IF-stage lookup; reads pre-edge table contents with no update forwarding.
  always_comb begin
    f_idx_s   = IDX_W'(pc_index(64'(bus.fetch_pc), IDX_W));
    f_tag_s   = TAG_W'(pc_tag(64'(bus.fetch_pc), IDX_W));
    f_hit_s   = valid_r[f_idx_s] && (tag_r[f_idx_s] == f_tag_s);
    f_taken_s = f_hit_s && ctr_s[f_idx_s][CTR_W-1];
  end

  assign bus.pred_taken  = f_taken_s;
  assign bus.pred_target = f_taken_s ? target_r[f_idx_s] : (bus.fetch_pc + ADDR_W'(4));

  // EX-stage table probe and mispredict classification.
  always_comb begin
    e_idx_s = IDX_W'(pc_index(64'(bus.ex_pc), IDX_W));
    e_tag_s = TAG_W'(pc_tag(64'(bus.ex_pc), IDX_W));
    e_hit_s = valid_r[e_idx_s] && (tag_r[e_idx_s] == e_tag_s);
    // The instruction sitting in EX during a redirect cycle is wrong-path.
    res_s   = bus.ex_valid && !redirect_r;
    cause_s = MP_NONE;
    if (!res_s) begin
      cause_s = MP_NONE;
    end else if (!bus.ex_is_branch) begin
      if (bus.ex_pred_taken) begin
        cause_s = MP_ALIAS;
      end else begin
        cause_s = MP_NONE;
      end
    end else if (bus.ex_pred_taken != bus.ex_taken) begin
      cause_s = MP_DIR;
    end else if (bus.ex_taken && (bus.ex_pred_target != bus.ex_target)) begin
      cause_s = MP_TGT;
    end else begin
      cause_s = MP_NONE;
    end
    mp_s = (cause_s != MP_NONE);
    if ((cause_s != MP_ALIAS) && bus.ex_taken) begin
      fix_pc_s = bus.ex_target;
    end else begin
      fix_pc_s = bus.ex_pc_4;
    end
  end

  // Single write port: allocate, retarget, invalidate, counter step.
  always_comb begin
    wr_alloc_s = res_s && bus.ex_is_branch && !e_hit_s && bus.ex_taken;
    wr_tgt_s   = res_s && bus.ex_is_branch && e_hit_s && bus.ex_taken;
    wr_inval_s = res_s && !bus.ex_is_branch && bus.ex_pred_taken;
    ctr_inc_s  = res_s && bus.ex_is_branch && e_hit_s && bus.ex_taken;
    ctr_dec_s  = res_s && bus.ex_is_branch && e_hit_s && !bus.ex_taken;
  end

  // Redirect pulse and corrected PC; the PC holds between mispredicts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      redirect_r    <= 1'b0;
      redirect_pc_r <= {ADDR_W{1'b0}};
    end else begin
      redirect_r <= mp_s;
      if (mp_s) begin
        redirect_pc_r <= fix_pc_s;
      end else begin
        redirect_pc_r <= redirect_pc_r;
      end
    end
  end

  assign bus.redirect    = redirect_r;
  assign bus.redirect_pc = redirect_pc_r;

  // Valid bits are the only table state that needs clearing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r <= {ENTRIES{1'b0}};
    end else if (wr_alloc_s) begin
      valid_r[e_idx_s] <= 1'b1;
    end else if (wr_inval_s) begin
      valid_r[e_idx_s] <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Tag and target storage, written only through the EX port.
  always_ff @(posedge clk) begin
    if (wr_alloc_s) begin
      tag_r[e_idx_s]    <= e_tag_s;
      target_r[e_idx_s] <= bus.ex_target;
    end else if (wr_tgt_s) begin
      target_r[e_idx_s] <= bus.ex_target;
    end
  end

  for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
    logic sel_s;
    assign sel_s = (e_idx_s == IDX_W'(i));

    branch_predict_unit_sat_counter #(.W(CTR_W)) u_ctr (
      .clk      (clk),
      .rst      (rst),
      .inc      (ctr_inc_s && sel_s),
      .dec      (ctr_dec_s && sel_s),
      .load     (wr_alloc_s && sel_s),
      .load_val (CTR_WEAK_T),
      .value    (ctr_s[i])
    );
  end

  // Aliased non-branches count as mispredicts but not as branches.
  branch_predict_unit_sat_counter #(.W(STAT_W)) u_branch_cnt (
    .clk      (clk),
    .rst      (rst),
    .inc      (res_s && bus.ex_is_branch),
    .dec      (1'b0),
    .load     (1'b0),
    .load_val ({STAT_W{1'b0}}),
    .value    (bus.branch_cnt)
  );

  branch_predict_unit_sat_counter #(.W(STAT_W)) u_mispredict_cnt (
    .clk      (clk),
    .rst      (rst),
    .inc      (mp_s),
    .dec      (1'b0),
    .load     (1'b0),
    .load_val ({STAT_W{1'b0}}),
    .value    (bus.mispredict_cnt)
  );

endmodule
